// File: rtl/serial_tx.sv
// serial_tx -- parallel-in, serial-out transmitter for the 8-bit serial link.
//
// A DATA_W-bit word is accepted over a load_valid/load_ready handshake and sent
// LSB first, one bit per cycle in which hold is low. so/so_en connect directly
// to the serial-in receiver's si/en. done pulses on the final bit of a frame
// and lines up with the receiver's carry-out.
//
// Optional build macro SERIAL_TX_PARITY_EN: when defined, an even-parity bit
// (PAR state) follows the data bits, and done/load_ready move to that cycle.
//
// Ports:
//   clk         rising-edge clock
//   rst         asynchronous active-high reset
//   load_valid  din holds a word to send
//   din         parallel word to transmit (DATA_W bits)
//   load_ready  transmitter can accept a word this cycle
//   hold        stall: freeze shifting while high
//   so          serial data out, LSB first
//   so_en       so carries a valid bit this cycle
//   done        single-cycle pulse on the last bit of a frame
//   busy        frame in progress
module serial_tx #(
   parameter int DATA_W = 8,
   parameter int CNT_W  = $clog2(DATA_W)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load_valid,
   input  logic [DATA_W-1:0] din,
   output logic              load_ready,
   input  logic              hold,
   output logic              so,
   output logic              so_en,
   output logic              done,
   output logic              busy
);

`ifdef SERIAL_TX_PARITY_EN
   typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, PAR = 2'd2} state_t;
`else
   typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;
`endif

   localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);

   state_t            state;
   logic [DATA_W-1:0] sreg;
   logic [CNT_W-1:0]  cnt;
   logic              last_bit;
   logic              frame_end;
   logic              take;
`ifdef SERIAL_TX_PARITY_EN
   logic              par;
`endif

   // Final data bit actually being sent this cycle.
   assign last_bit = (state == SHIFT) && (cnt == LAST) && !hold;

`ifdef SERIAL_TX_PARITY_EN
   assign frame_end = (state == PAR) && !hold;
`else
   assign frame_end = last_bit;
`endif

   // The frame-end cycle also accepts the next word, so frames can run
   // back-to-back without an idle gap.
   assign load_ready = !rst && ((state == IDLE) || frame_end);
   assign take       = load_valid && load_ready;

   always_comb begin
      so    = 1'b0;
      so_en = 1'b0;
      done  = frame_end;
      busy  = (state != IDLE);
      case (state)
         SHIFT: begin
            so    = sreg[0];
            so_en = !hold;
         end
`ifdef SERIAL_TX_PARITY_EN
         PAR: begin
            so    = par;
            so_en = !hold;
         end
`endif
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         sreg  <= '0;
         cnt   <= '0;
`ifdef SERIAL_TX_PARITY_EN
         par   <= 1'b0;
`endif
      end else begin
         case (state)
            SHIFT: begin
               if (!hold) begin
                  sreg <= sreg >> 1;
                  if (cnt == LAST) begin
                     cnt <= '0;
`ifdef SERIAL_TX_PARITY_EN
                     state <= PAR;
`else
                     state <= IDLE;
`endif
                  end else begin
                     cnt <= cnt + CNT_W'(1);
                  end
               end
            end
`ifdef SERIAL_TX_PARITY_EN
            PAR: begin
               if (!hold) state <= IDLE;
            end
`endif
            default: state <= IDLE;
         endcase
         // A capture overrides the frame-end transition above (last NBA wins).
         if (take) begin
            sreg  <= din;
            cnt   <= '0;
            state <= SHIFT;
`ifdef SERIAL_TX_PARITY_EN
            par   <= ^din;
`endif
         end
      end
   end

endmodule

// File: tb/tb_serial_tx.sv
// Testbench for serial_tx: scoreboard of expected (bit, done) pairs consumed by
// a monitor on every so_en cycle, plus a receiver model fed by so/so_en that
// reassembles words for comparison after its carry-out.
module tb_serial_tx;
   localparam int DATA_W = 8;
`ifdef SERIAL_TX_PARITY_EN
   localparam int FL = DATA_W + 1;
`else
   localparam int FL = DATA_W;
`endif

   logic              clk;
   logic              rst;
   logic              load_valid;
   logic [DATA_W-1:0] din;
   logic              load_ready;
   logic              hold;
   logic              so;
   logic              so_en;
   logic              done;
   logic              busy;

   serial_tx #(.DATA_W(DATA_W)) dut (
      .clk(clk), .rst(rst), .load_valid(load_valid), .din(din),
      .load_ready(load_ready), .hold(hold), .so(so), .so_en(so_en),
      .done(done), .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic b;
      logic d;
   } exp_t;

   exp_t              exp_q[$];
   logic [DATA_W-1:0] word_q[$];
   int                total = 0;
   int                bad   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
      end
   endtask

   // Expected bits are the hand-listed word LSB first; p is the hand-computed
   // even-parity bit (used only when the parity build is enabled).
   task automatic push_frame(input logic [DATA_W-1:0] w, input logic p);
      logic [DATA_W-1:0] v;
      v = w;
      for (int i = 0; i < DATA_W; i++) begin
         exp_q.push_back('{b: v[i], d: (i == FL - 1)});
      end
`ifdef SERIAL_TX_PARITY_EN
      exp_q.push_back('{b: p, d: 1'b1});
`else
      if (p) begin end
`endif
      word_q.push_back(w);
   endtask

   // Present a word and wait (bounded) for the handshake; returns just after
   // the accepting edge, i.e. in cycle N+1.
   task automatic accept(input logic [DATA_W-1:0] w, input logic p, input logic keep);
      int t;
      t = 0;
      din = w;
      load_valid = 1'b1;
      push_frame(w, p);
      @(negedge clk);
      while (!load_ready && t < 100) begin
         @(negedge clk);
         t++;
      end
      if (t >= 100) begin
         total++;
         bad++;
         $display("FAIL accept_timeout word=%0h load_ready=%0b required=1", w, load_ready);
      end
      @(posedge clk);
      #1;
      if (!keep) load_valid = 1'b0;
   endtask

   task automatic send(input logic [DATA_W-1:0] w, input logic p);
      accept(w, p, 1'b0);
      repeat (FL + 1) @(posedge clk);
      #1;
   endtask

   // Receiver model: the team's serial-in receiver, si=so, en=so_en.
   logic [DATA_W-1:0] rx_word;
   int                rx_cnt;
   logic              rx_co;
   logic              rx_pend;

   assign rx_co = so_en && (rx_cnt == FL - 1);

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_cnt  <= 0;
         rx_word <= '0;
      end else if (so_en) begin
         if (rx_cnt < DATA_W) rx_word <= {so, rx_word[DATA_W-1:1]};
         rx_cnt <= (rx_cnt == FL - 1) ? 0 : rx_cnt + 1;
      end
   end

   // Monitor
   initial rx_pend = 1'b0;
   always @(negedge clk) begin
      exp_t e;
      logic [DATA_W-1:0] w;
      if (rst) begin
         rx_pend = 1'b0;
      end else begin
         if (rx_pend) begin
            rx_pend = 1'b0;
            total++;
            if (word_q.size() == 0) begin
               bad++;
               $display("FAIL rx_word actual=%0h required=none", rx_word);
            end else begin
               w = word_q.pop_front();
               if (rx_word !== w) begin
                  bad++;
                  $display("FAIL rx_word actual=%0h required=%0h", rx_word, w);
               end
            end
         end
         if (so_en) begin
            total++;
            if (exp_q.size() == 0) begin
               bad++;
               $display("FAIL stale_bit so=%0b done=%0b required=no bit", so, done);
            end else begin
               e = exp_q.pop_front();
               if (so !== e.b || done !== e.d) begin
                  bad++;
                  $display("FAIL bit so=%0b done=%0b required so=%0b done=%0b t=%0t",
                           so, done, e.b, e.d, $time);
               end
            end
            if (rx_co) begin
               chk("co_vs_done", {31'd0, done}, 32'd1);
               rx_pend = 1'b1;
            end
         end else begin
            chk("done_without_en", {31'd0, done}, 32'd0);
         end
      end
   end

   initial begin
      int t;
      rst = 1'b0;
      load_valid = 1'b0;
      din = '0;
      hold = 1'b0;
      #2 rst = 1'b1;
      #1;
      chk("rst_load_ready", {31'd0, load_ready}, 32'd0);
      chk("rst_so",         {31'd0, so},         32'd0);
      chk("rst_so_en",      {31'd0, so_en},      32'd0);
      chk("rst_done",       {31'd0, done},       32'd0);
      chk("rst_busy",       {31'd0, busy},       32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      chk("idle_load_ready", {31'd0, load_ready}, 32'd1);
      chk("idle_busy",       {31'd0, busy},       32'd0);

      // Single frame A5
      accept(8'hA5, 1'b0, 1'b0);
      for (int i = 1; i <= FL; i++) begin
         @(negedge clk);
         chk("a5_so_en", {31'd0, so_en}, 32'd1);
         chk("a5_load_ready", {31'd0, load_ready}, {31'd0, (i == FL)});
         chk("a5_busy", {31'd0, busy}, 32'd1);
         @(posedge clk);
         #1;
      end
      @(negedge clk);
      chk("a5_after_so_en", {31'd0, so_en}, 32'd0);
      chk("a5_after_busy",  {31'd0, busy},  32'd0);
      @(posedge clk);
      #1;

      // Back-to-back 01 then 80
      accept(8'h01, 1'b1, 1'b1);
      din = 8'h80;
      push_frame(8'h80, 1'b1);
      for (int i = 1; i <= 2 * FL; i++) begin
         @(negedge clk);
         chk("b2b_so_en", {31'd0, so_en}, 32'd1);
         chk("b2b_load_ready", {31'd0, load_ready}, {31'd0, (i == FL || i == 2 * FL)});
         @(posedge clk);
         #1;
         if (i == FL) load_valid = 1'b0;
      end
      @(negedge clk);
      chk("b2b_after_so_en", {31'd0, so_en}, 32'd0);
      @(posedge clk);
      #1;

      // Hold during N+3..N+5 on F0
      accept(8'hF0, 1'b0, 1'b0);
      for (int k = 1; k <= FL + 3; k++) begin
         hold = (k >= 3 && k <= 5);
         @(negedge clk);
         chk("hold_so_en", {31'd0, so_en}, {31'd0, !(k >= 3 && k <= 5)});
         if (k >= 3 && k <= 5) begin
            chk("hold_so", {31'd0, so}, 32'd0);
            chk("hold_done", {31'd0, done}, 32'd0);
            chk("hold_busy", {31'd0, busy}, 32'd1);
         end
         @(posedge clk);
         #1;
      end
      hold = 1'b0;
      @(negedge clk);
      chk("hold_after_busy", {31'd0, busy}, 32'd0);
      @(posedge clk);
      #1;

      // Reset mid-frame at N+4
      accept(8'hFF, 1'b0, 1'b0);
      repeat (3) @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      chk("midrst_so_en",      {31'd0, so_en},      32'd0);
      chk("midrst_done",       {31'd0, done},       32'd0);
      chk("midrst_busy",       {31'd0, busy},       32'd0);
      chk("midrst_load_ready", {31'd0, load_ready}, 32'd0);
      exp_q.delete();
      word_q.delete();
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      send(8'h3C, 1'b0);
      chk("midrst_drained", exp_q.size(), 32'd0);

      // Loopback words
      send(8'h00, 1'b0);
      send(8'hFF, 1'b0);
      send(8'h5A, 1'b0);
      send(8'hC3, 1'b0);
`ifdef SERIAL_TX_PARITY_EN
      send(8'h07, 1'b1);
      send(8'h03, 1'b0);
`endif

      t = 0;
      while ((exp_q.size() != 0 || word_q.size() != 0) && t < 100) begin
         @(posedge clk);
         t++;
      end
      #1;
      chk("final_drain", exp_q.size() + word_q.size(), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
